// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the sequencer state encoding and the init fill-value rule.
package reg_file_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    // Wide enough for any practical DATA_W; callers cast down to their width.
    localparam int FILL_W = 64;

    function automatic logic [FILL_W-1:0] fill_value(input int mode, input logic [FILL_W-1:0] idx);
        logic [FILL_W-1:0] val;
        val = '0;
        if (mode == INIT_INDEX) begin
            val = idx;
        end
        return val;
    endfunction

endpackage

// File: rtl/reg_file_init_seq.sv
// Post-reset init sequencer: walks registers 1..DEPTH-1 writing the fill value,
// then moves to RUN and raises ready on the same edge as the last write.
module reg_file_init_seq
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    output state_t            state,
    output logic              ready,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    logic [ADDR_W-1:0] init_cnt;

    // The counter holds at the last index instead of wrapping, so it never revisits 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= {{(ADDR_W-1){1'b0}}, 1'b1};
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == LAST_IDX) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign init_we   = (state == ST_INIT);
    assign init_addr = init_cnt;
    assign init_data = DATA_W'(fill_value(INIT_MODE, FILL_W'(init_cnt)));

endmodule

// File: rtl/reg_file_mp.sv
// Two-read, two-write register file with hardwired-zero r0, optional
// write-to-read bypass and a hardware fill sequence after every reset.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    logic              running;
    logic              w0_live;
    logic              w1_live;

    logic [DATA_W-1:0] regs [0:DEPTH-1];

    logic [ADDR_W-1:0] rd_addr [0:1];
    logic [DATA_W-1:0] rd_data [0:1];

    reg_file_init_seq #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_MODE(INIT_MODE)
    ) u_init_seq (
        .clock    (clock),
        .reset_n  (reset_n),
        .state    (state),
        .ready    (ready),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_data(init_data)
    );

    assign running = (state == ST_RUN);
    assign w0_live = running && w0_en && (w0_addr != '0);
    assign w1_live = running && w1_en && (w1_addr != '0);

    // Array is deliberately not reset; the sequencer rewrites it. Port 1 is
    // written last so it overrides port 0 on an address collision.
    always_ff @(posedge clock) begin
        if (init_we) begin
            regs[init_addr] <= init_data;
        end else begin
            if (w0_live) begin
                regs[w0_addr] <= w0_data;
            end
            if (w1_live) begin
                regs[w1_addr] <= w1_data;
            end
        end
    end

    assign rd_addr[0] = a_addr;
    assign rd_addr[1] = b_addr;

    // Reads are forced to zero outside RUN so unfilled contents never escape.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (running && (rd_addr[p] != '0)) begin
                rd_data[p] = regs[rd_addr[p]];
                if (BYPASS != 0) begin
                    if (w0_live && (w0_addr == rd_addr[p])) begin
                        rd_data[p] = w0_data;
                    end
                    if (w1_live && (w1_addr == rd_addr[p])) begin
                        rd_data[p] = w1_data;
                    end
                end
            end
        end
    end

    assign a_data = rd_data[0];
    assign b_data = rd_data[1];

endmodule
